sdrc_bank_arb: RTL and testbench

- Sits between the four per-bank FSMs and the transfer controller (xfr_ctl).
- Selects one bank command per cycle (PRE/ACT/RD/WR) and forwards it to xfr_ctl.
- Routes xfr_ctl's accept (ack) back to the granted bank.
- Enforces tRRD between ACT commands and exports the resulting activate-OK status to all banks.

---
 rtl/sdrc_bank_arb.sv | 171 +++++++++++++++++
 tb/tb_sdrc_bank_arb.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sdrc_bank_arb.sv
// sdrc_bank_arb: picks one of four bank commands per cycle for xfr_ctl,
// holds a grant until xfr_ctl accepts it, and spaces ACT commands by tRRD.
`ifndef SDR_REQ_ID_W
`define SDR_REQ_ID_W 4
`endif
`ifndef REQ_BW
`define REQ_BW 7
`endif
`ifndef OP_PRE
`define OP_PRE 2'b00
`endif
`ifndef OP_ACT
`define OP_ACT 2'b01
`endif
`ifndef OP_RD
`define OP_RD 2'b10
`endif
`ifndef OP_WR
`define OP_WR 2'b11
`endif

module sdrc_bank_arb #(
  parameter int NB    = 4,
  parameter int ID_W  = `SDR_REQ_ID_W,
  parameter int LEN_W = `REQ_BW
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NB-1:0]        b2a_req,
  input  logic [2*NB-1:0]      b2a_cmd,
  input  logic [13*NB-1:0]     b2a_addr,
  input  logic [NB*ID_W-1:0]   b2a_id,
  input  logic [NB*LEN_W-1:0]  b2a_len,
  input  logic [NB-1:0]        b2a_start,
  input  logic [NB-1:0]        b2a_last,
  input  logic [NB-1:0]        b2a_wrap,
  output logic [NB-1:0]        a2b_ack,
  output logic                 a2b_act_ok,
  output logic                 a2x_req,
  output logic [1:0]           a2x_ba,
  output logic [1:0]           a2x_cmd,
  output logic [12:0]          a2x_addr,
  output logic [ID_W-1:0]      a2x_id,
  output logic [LEN_W-1:0]     a2x_len,
  output logic                 a2x_start,
  output logic                 a2x_last,
  output logic                 a2x_wrap,
  input  logic                 x2a_ack,
  input  logic [3:0]           trrd_delay
);

  logic [1:0]       rr_ptr_q, rr_ptr_d;
  logic             lock_vld_q, lock_vld_d;
  logic [1:0]       lock_bank_q, lock_bank_d;
  logic [3:0]       trrd_cnt_q, trrd_cnt_d;
  logic             act_ok_q, act_ok_d;

  logic [1:0]       cmd_arr_s  [NB];
  logic [12:0]      addr_arr_s [NB];
  logic [ID_W-1:0]  id_arr_s   [NB];
  logic [LEN_W-1:0] len_arr_s  [NB];
  logic [NB-1:0]    elig_s, cls_a_s, cls_b_s;
  logic [2:0]       pick_a_s, pick_b_s;
  logic             lock_hold_s, gnt_vld_s;
  logic [1:0]       gnt_bank_s;

  // First set bit of mask scanning ptr, ptr+1, ... (mod 4); returns {found, index}.
  function automatic logic [2:0] rr_pick(input logic [3:0] mask, input logic [1:0] ptr);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      idx = ptr + 2'(i);
      if (mask[idx]) begin
        res = {1'b1, idx};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  // Unpack the per-bank buses and classify eligible requests.
  always_comb begin
    for (int k = 0; k < NB; k++) begin
      cmd_arr_s[k]  = b2a_cmd[2*k +: 2];
      addr_arr_s[k] = b2a_addr[13*k +: 13];
      id_arr_s[k]   = b2a_id[ID_W*k +: ID_W];
      len_arr_s[k]  = b2a_len[LEN_W*k +: LEN_W];
      elig_s[k]     = b2a_req[k] & ~((cmd_arr_s[k] == `OP_ACT) & ~act_ok_q);
      cls_a_s[k]    = elig_s[k] & ((cmd_arr_s[k] == `OP_PRE) | (cmd_arr_s[k] == `OP_ACT));
      cls_b_s[k]    = elig_s[k] & ~((cmd_arr_s[k] == `OP_PRE) | (cmd_arr_s[k] == `OP_ACT));
    end
  end

  // Grant selection: a held lock wins, then PRE/ACT, then RD/WR, round robin inside a class.
  always_comb begin
    pick_a_s    = rr_pick(cls_a_s, rr_ptr_q);
    pick_b_s    = rr_pick(cls_b_s, rr_ptr_q);
    lock_hold_s = lock_vld_q & b2a_req[lock_bank_q];
    if (lock_hold_s) begin
      // A locked ACT still waits for tRRD; nobody else may slip in meanwhile.
      gnt_vld_s  = ~((cmd_arr_s[lock_bank_q] == `OP_ACT) & ~act_ok_q);
      gnt_bank_s = lock_bank_q;
    end else if (pick_a_s[2]) begin
      gnt_vld_s  = 1'b1;
      gnt_bank_s = pick_a_s[1:0];
    end else if (pick_b_s[2]) begin
      gnt_vld_s  = 1'b1;
      gnt_bank_s = pick_b_s[1:0];
    end else begin
      gnt_vld_s  = 1'b0;
      gnt_bank_s = 2'b00;
    end
  end

  // Forward the granted bank's command to xfr_ctl and route the accept back.
  always_comb begin
    a2x_req    = gnt_vld_s & reset_n;
    a2x_ba     = gnt_bank_s;
    a2x_cmd    = cmd_arr_s[gnt_bank_s];
    a2x_addr   = addr_arr_s[gnt_bank_s];
    a2x_id     = id_arr_s[gnt_bank_s];
    a2x_len    = len_arr_s[gnt_bank_s];
    a2x_start  = b2a_start[gnt_bank_s];
    a2x_last   = b2a_last[gnt_bank_s];
    a2x_wrap   = b2a_wrap[gnt_bank_s];
    a2b_act_ok = act_ok_q;
    for (int k = 0; k < NB; k++) begin
      a2b_ack[k] = x2a_ack & a2x_req & (gnt_bank_s == 2'(k));
    end
  end

  // Next-state for round robin pointer, grant lock and tRRD counter.
  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    lock_bank_d = lock_bank_q;
    trrd_cnt_d  = (trrd_cnt_q != 4'd0) ? (trrd_cnt_q - 4'd1) : 4'd0;
    if (a2x_req && x2a_ack) begin
      rr_ptr_d   = gnt_bank_s + 2'd1;
      lock_vld_d = 1'b0;
      trrd_cnt_d = (a2x_cmd == `OP_ACT) ? trrd_delay : trrd_cnt_d;
    end else if (a2x_req) begin
      lock_vld_d  = 1'b1;
      lock_bank_d = gnt_bank_s;
    end else if (lock_vld_q && !b2a_req[lock_bank_q]) begin
      lock_vld_d = 1'b0;
    end else begin
      lock_vld_d = lock_vld_q;
    end
    act_ok_d = (trrd_cnt_d == 4'd0);
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rr_ptr_q    <= 2'd0;
      lock_vld_q  <= 1'b0;
      lock_bank_q <= 2'd0;
      trrd_cnt_q  <= 4'd0;
      act_ok_q    <= 1'b1;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      lock_vld_q  <= lock_vld_d;
      lock_bank_q <= lock_bank_d;
      trrd_cnt_q  <= trrd_cnt_d;
      act_ok_q    <= act_ok_d;
    end
  end

endmodule

// File: tb/tb_sdrc_bank_arb.sv
// Self-checking bench for sdrc_bank_arb: directed scenarios followed by random
// traffic, every cycle compared against a behavioural arbitration model.
module tb_sdrc_bank_arb;

  localparam int ID_W  = 4;
  localparam int LEN_W = 7;
  localparam logic [1:0] OP_PRE = 2'd0;
  localparam logic [1:0] OP_ACT = 2'd1;
  localparam logic [1:0] OP_RD  = 2'd2;
  localparam logic [1:0] OP_WR  = 2'd3;

  logic               clk;
  logic               reset_n;
  logic [3:0]         b2a_req;
  logic [7:0]         b2a_cmd;
  logic [51:0]        b2a_addr;
  logic [4*ID_W-1:0]  b2a_id;
  logic [4*LEN_W-1:0] b2a_len;
  logic [3:0]         b2a_start, b2a_last, b2a_wrap;
  logic [3:0]         a2b_ack;
  logic               a2b_act_ok, a2x_req;
  logic [1:0]         a2x_ba, a2x_cmd;
  logic [12:0]        a2x_addr;
  logic [ID_W-1:0]    a2x_id;
  logic [LEN_W-1:0]   a2x_len;
  logic               a2x_start, a2x_last, a2x_wrap;
  logic               x2a_ack;
  logic [3:0]         trrd_delay;

  logic [1:0]       t_cmd  [4];
  logic [12:0]      t_addr [4];
  logic [ID_W-1:0]  t_id   [4];
  logic [LEN_W-1:0] t_len  [4];
  logic [2:0]       t_flg  [4];

  int n_checks, n_errors;
  int m_rr, m_lock, m_lockb, m_trrd;
  int obs_ba, obs_req, obs_act_ok;

  sdrc_bank_arb #(.NB(4), .ID_W(ID_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .b2a_req(b2a_req), .b2a_cmd(b2a_cmd), .b2a_addr(b2a_addr), .b2a_id(b2a_id),
    .b2a_len(b2a_len), .b2a_start(b2a_start), .b2a_last(b2a_last), .b2a_wrap(b2a_wrap),
    .a2b_ack(a2b_ack), .a2b_act_ok(a2b_act_ok), .a2x_req(a2x_req), .a2x_ba(a2x_ba),
    .a2x_cmd(a2x_cmd), .a2x_addr(a2x_addr), .a2x_id(a2x_id), .a2x_len(a2x_len),
    .a2x_start(a2x_start), .a2x_last(a2x_last), .a2x_wrap(a2x_wrap),
    .x2a_ack(x2a_ack), .trrd_delay(trrd_delay)
  );

  always #5 clk = ~clk;

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      b2a_cmd[2*k +: 2]          = t_cmd[k];
      b2a_addr[13*k +: 13]       = t_addr[k];
      b2a_id[ID_W*k +: ID_W]     = t_id[k];
      b2a_len[LEN_W*k +: LEN_W]  = t_len[k];
      b2a_start[k]               = t_flg[k][2];
      b2a_last[k]                = t_flg[k][1];
      b2a_wrap[k]                = t_flg[k][0];
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic set_bank(input int k, input logic r, input logic [1:0] c);
    b2a_req[k] = r;
    t_cmd[k]   = c;
    t_addr[k]  = 13'($urandom);
    t_id[k]    = ID_W'($urandom);
    t_len[k]   = LEN_W'($urandom);
    t_flg[k]   = 3'($urandom);
  endtask

  task automatic clear_banks();
    for (int k = 0; k < 4; k++) set_bank(k, 1'b0, OP_RD);
  endtask

  // Reference model: compute the expected grant for this cycle, compare, then advance.
  task automatic step();
    int g, nt;
    bit act_ok, is_a;
    logic [3:0] exp_ack;
    act_ok = (m_trrd == 0);
    g = -1;
    if (reset_n) begin
      if (m_lock != 0 && b2a_req[m_lockb]) begin
        if (!(t_cmd[m_lockb] == OP_ACT && !act_ok)) g = m_lockb;
      end else begin
        for (int cls = 0; cls < 2; cls++) begin
          for (int i = 0; i < 4; i++) begin
            int k;
            k = (m_rr + i) % 4;
            is_a = (t_cmd[k] == OP_PRE) || (t_cmd[k] == OP_ACT);
            if (g < 0 && b2a_req[k] && !(t_cmd[k] == OP_ACT && !act_ok) && (is_a == (cls == 0)))
              g = k;
          end
        end
      end
    end
    exp_ack = (g >= 0 && x2a_ack) ? 4'(1 << g) : 4'd0;
    obs_ba = 32'(a2x_ba); obs_req = 32'(a2x_req); obs_act_ok = 32'(a2b_act_ok);
    check_eq("a2x_req", 32'(a2x_req), 32'(g >= 0));
    check_eq("a2b_ack", 32'(a2b_ack), 32'(exp_ack));
    check_eq("act_ok", 32'(a2b_act_ok), 32'(act_ok));
    if (g >= 0) begin
      check_eq("a2x_ba", 32'(a2x_ba), 32'(g));
      check_eq("a2x_cmd", 32'(a2x_cmd), 32'(t_cmd[g]));
      check_eq("a2x_addr", 32'(a2x_addr), 32'(t_addr[g]));
      check_eq("a2x_id_len", {16'(a2x_id), 16'(a2x_len)}, {16'(t_id[g]), 16'(t_len[g])});
      check_eq("a2x_flags", 32'({a2x_start, a2x_last, a2x_wrap}), 32'(t_flg[g]));
    end
    if (!reset_n) begin
      m_rr = 0; m_lock = 0; m_lockb = 0; m_trrd = 0;
    end else begin
      nt = (m_trrd > 0) ? m_trrd - 1 : 0;
      if (g >= 0 && x2a_ack) begin
        m_rr = (g + 1) % 4;
        m_lock = 0;
        if (t_cmd[g] == OP_ACT) nt = int'(trrd_delay);
      end else if (g >= 0) begin
        m_lock = 1;
        m_lockb = g;
      end else if (m_lock != 0 && !b2a_req[m_lockb]) begin
        m_lock = 0;
      end
      m_trrd = nt;
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clk = 1'b0; reset_n = 1'b0; x2a_ack = 1'b1; trrd_delay = 4'd0;
    n_checks = 0; n_errors = 0;
    m_rr = 0; m_lock = 0; m_lockb = 0; m_trrd = 0;
    for (int k = 0; k < 4; k++) set_bank(k, 1'b1, OP_RD);
    repeat (2) cycle();
    check_eq("rst_no_req", 32'(obs_req), 32'd0);
    reset_n = 1'b1;

    // Round robin over four RD requesters, accepted every cycle.
    for (int i = 0; i < 5; i++) begin
      cycle();
      check_eq("rr_seq", 32'(obs_ba), 32'(i % 4));
    end
    if (!obs_act_ok[0]) check_eq("act_ok_after_rst", 32'(obs_act_ok), 32'd1);

    // PRE beats WR even though the pointer favours bank1.
    clear_banks();
    set_bank(1, 1'b1, OP_WR);
    set_bank(2, 1'b1, OP_PRE);
    cycle();
    check_eq("cls_a_first", 32'(obs_ba), 32'd2);
    b2a_req[2] = 1'b0;
    cycle();
    check_eq("cls_b_next", 32'(obs_ba), 32'd1);

    // tRRD = 3 after ACT on bank0; RD slips through, bank3 ACT waits until t+4.
    clear_banks();
    trrd_delay = 4'd3;
    set_bank(0, 1'b1, OP_ACT);
    cycle();
    check_eq("act_t", 32'(obs_ba), 32'd0);
    clear_banks();
    set_bank(3, 1'b1, OP_ACT);
    set_bank(1, 1'b1, OP_RD);
    cycle();
    check_eq("trrd_rd_t1", 32'(obs_ba), 32'd1);
    check_eq("trrd_blk_t1", 32'(obs_act_ok), 32'd0);
    b2a_req[1] = 1'b0;
    for (int i = 2; i <= 3; i++) begin
      cycle();
      check_eq("trrd_blk", 32'(obs_req), 32'd0);
    end
    cycle();
    check_eq("trrd_t4_ok", 32'(obs_act_ok), 32'd1);
    check_eq("trrd_t4_ba", 32'(obs_ba), 32'd3);

    // Lock on bank2 survives a PRE arriving; dropping req hands over to bank0.
    clear_banks();
    x2a_ack = 1'b0;
    set_bank(2, 1'b1, OP_RD);
    cycle();
    set_bank(0, 1'b1, OP_PRE);
    repeat (2) begin
      cycle();
      check_eq("lock_hold", 32'(obs_ba), 32'd2);
    end
    b2a_req[2] = 1'b0;
    cycle();
    check_eq("lock_drop", 32'(obs_ba), 32'd0);
    x2a_ack = 1'b1;
    cycle();
    clear_banks();

    // Reset while locked with trrd_cnt = 5 clears everything.
    trrd_delay = 4'd5;
    set_bank(1, 1'b1, OP_ACT);
    cycle();
    clear_banks();
    x2a_ack = 1'b0;
    set_bank(2, 1'b1, OP_RD);
    cycle();
    reset_n = 1'b0;
    x2a_ack = 1'b1;
    cycle();
    reset_n = 1'b1;
    clear_banks();
    cycle();
    check_eq("rst_act_ok", 32'(obs_act_ok), 32'd1);
    for (int k = 1; k < 4; k++) set_bank(k, 1'b1, OP_RD);
    cycle();
    check_eq("rst_rr_ptr", 32'(obs_ba), 32'd1);

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      for (int k = 0; k < 4; k++) begin
        if ($urandom_range(0, 3) == 0) set_bank(k, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
      end
      x2a_ack = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 31) == 0) trrd_delay = 4'($urandom_range(0, 6));
      reset_n = ($urandom_range(0, 99) != 0);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
